// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: shares a simple dual-port bRAM (port A write, port B read)
// between two writers and two readers. Each port has its own round-robin
// arbiter, and read responses are steered back to the issuing reader by a tag
// pipeline that runs in step with the bRAM read latency.
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   wr{0,1}_valid/ready/addr/data  write requesters (ready is combinational)
//   rd{0,1}_valid/ready/addr       read requesters (ready is combinational)
//   rd{0,1}_rvalid/rdata           read responses (one-cycle rvalid pulse)
//   bram_addra/dina/wea            registered bRAM write port
//   bram_addrb                     registered bRAM read address
//   bram_doutb                     bRAM read data, RD_LAT clocks after addrb
//
// Optional feature macro: BRAM_RAW_BYPASS_EN. When it is defined, a read and a
// write that reach the bRAM in the same cycle at the same address return the
// new write data instead of the bRAM collision result.
module bram_port_arbiter #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr0_valid,
    output logic              wr0_ready,
    input  logic [ADDR_W-1:0] wr0_addr,
    input  logic [DATA_W-1:0] wr0_data,
    input  logic              wr1_valid,
    output logic              wr1_ready,
    input  logic [ADDR_W-1:0] wr1_addr,
    input  logic [DATA_W-1:0] wr1_data,
    input  logic              rd0_valid,
    output logic              rd0_ready,
    input  logic [ADDR_W-1:0] rd0_addr,
    output logic              rd0_rvalid,
    output logic [DATA_W-1:0] rd0_rdata,
    input  logic              rd1_valid,
    output logic              rd1_ready,
    input  logic [ADDR_W-1:0] rd1_addr,
    output logic              rd1_rvalid,
    output logic [DATA_W-1:0] rd1_rdata,
    output logic [ADDR_W-1:0] bram_addra,
    output logic [DATA_W-1:0] bram_dina,
    output logic              bram_wea,
    output logic [ADDR_W-1:0] bram_addrb,
    input  logic [DATA_W-1:0] bram_doutb
);

    localparam int unsigned PIPE_W = RD_LAT + 1;

    // Round-robin pointers: 1 means requester 1 is favoured on a tie.
    logic wr_ptr;
    logic rd_ptr;

    logic wr_gnt1_c;
    logic rd_gnt1_c;
    logic wr_hs_c;
    logic rd_hs_c;

    // Read tag pipeline; stage 0 is aligned with bram_addrb.
    logic [PIPE_W-1:0] pv;
    logic [PIPE_W-1:0] ptag;

    logic [DATA_W-1:0] rd0_hold;
    logic [DATA_W-1:0] rd1_hold;
    logic [DATA_W-1:0] resp_data_c;

    // Grant requester 1 only if it is the sole requester or it is favoured.
    assign wr_gnt1_c = wr1_valid & (~wr0_valid | wr_ptr);
    assign rd_gnt1_c = rd1_valid & (~rd0_valid | rd_ptr);

    // Exactly one ready per port outside reset; none during reset.
    assign wr0_ready = rst_n & ~wr_gnt1_c;
    assign wr1_ready = rst_n &  wr_gnt1_c;
    assign rd0_ready = rst_n & ~rd_gnt1_c;
    assign rd1_ready = rst_n &  rd_gnt1_c;

    assign wr_hs_c = (wr0_valid & wr0_ready) | (wr1_valid & wr1_ready);
    assign rd_hs_c = (rd0_valid & rd0_ready) | (rd1_valid & rd1_ready);

    // Pointer flips to the loser only when a transfer happens.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (wr_hs_c) wr_ptr <= ~wr_gnt1_c;
            if (rd_hs_c) rd_ptr <= ~rd_gnt1_c;
        end
    end

    // Write port register stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bram_wea   <= 1'b0;
            bram_addra <= '0;
            bram_dina  <= '0;
        end else begin
            bram_wea <= wr_hs_c;
            if (wr_hs_c) begin
                bram_addra <= wr_gnt1_c ? wr1_addr : wr0_addr;
                bram_dina  <= wr_gnt1_c ? wr1_data : wr0_data;
            end
        end
    end

    // Read address register and tag/valid shift pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bram_addrb <= '0;
            pv         <= '0;
            ptag       <= '0;
        end else begin
            if (rd_hs_c) bram_addrb <= rd_gnt1_c ? rd1_addr : rd0_addr;
            pv   <= {pv[PIPE_W-2:0], rd_hs_c};
            ptag <= {ptag[PIPE_W-2:0], rd_gnt1_c};
        end
    end

`ifdef BRAM_RAW_BYPASS_EN
    // Collision detected while addr/data sit on the bRAM pins, then delayed
    // to line up with bram_doutb.
    logic [RD_LAT:1]   byp_hit;
    logic [DATA_W-1:0] byp_data [RD_LAT:1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byp_hit <= '0;
            for (int i = 1; i <= int'(RD_LAT); i++) byp_data[i] <= '0;
        end else begin
            byp_hit[1]  <= bram_wea & pv[0] & (bram_addra == bram_addrb);
            byp_data[1] <= bram_dina;
            for (int i = 2; i <= int'(RD_LAT); i++) begin
                byp_hit[i]  <= byp_hit[i-1];
                byp_data[i] <= byp_data[i-1];
            end
        end
    end

    assign resp_data_c = byp_hit[RD_LAT] ? byp_data[RD_LAT] : bram_doutb;
`else
    assign resp_data_c = bram_doutb;
`endif

    // Responses decoded straight from pipeline flops so rvalid lines up with doutb.
    assign rd0_rvalid = pv[RD_LAT] & ~ptag[RD_LAT];
    assign rd1_rvalid = pv[RD_LAT] &  ptag[RD_LAT];

    // Last delivered data is held while no response is pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd0_hold <= '0;
            rd1_hold <= '0;
        end else begin
            if (rd0_rvalid) rd0_hold <= resp_data_c;
            if (rd1_rvalid) rd1_hold <= resp_data_c;
        end
    end

    assign rd0_rdata = rd0_rvalid ? resp_data_c : rd0_hold;
    assign rd1_rdata = rd1_rvalid ? resp_data_c : rd1_hold;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed testbench for bram_port_arbiter with a read-first bRAM model (RD_LAT=1).
module tb_bram_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        wr0_valid, wr0_ready;
    logic [3:0]  wr0_addr;
    logic [15:0] wr0_data;
    logic        wr1_valid, wr1_ready;
    logic [3:0]  wr1_addr;
    logic [15:0] wr1_data;
    logic        rd0_valid, rd0_ready, rd0_rvalid;
    logic [3:0]  rd0_addr;
    logic [15:0] rd0_rdata;
    logic        rd1_valid, rd1_ready, rd1_rvalid;
    logic [3:0]  rd1_addr;
    logic [15:0] rd1_rdata;
    logic [3:0]  bram_addra, bram_addrb;
    logic [15:0] bram_dina, bram_doutb;
    logic        bram_wea;

    int vectors;
    int miscompares;

    logic [15:0] mem [0:15];

    bram_port_arbiter #(.ADDR_W(4), .DATA_W(16), .RD_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr0_valid(wr0_valid), .wr0_ready(wr0_ready), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_valid(wr1_valid), .wr1_ready(wr1_ready), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .rd0_valid(rd0_valid), .rd0_ready(rd0_ready), .rd0_addr(rd0_addr),
        .rd0_rvalid(rd0_rvalid), .rd0_rdata(rd0_rdata),
        .rd1_valid(rd1_valid), .rd1_ready(rd1_ready), .rd1_addr(rd1_addr),
        .rd1_rvalid(rd1_rvalid), .rd1_rdata(rd1_rdata),
        .bram_addra(bram_addra), .bram_dina(bram_dina), .bram_wea(bram_wea),
        .bram_addrb(bram_addrb), .bram_doutb(bram_doutb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read-first simple dual-port bRAM, one clock read latency.
    always @(posedge clk) begin
        if (bram_wea) mem[bram_addra] <= bram_dina;
        bram_doutb <= mem[bram_addrb];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr0_valid = 0; wr1_valid = 0; rd0_valid = 0; rd1_valid = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wea"},    32'(bram_wea),   0);
        check({tag, "_addra"},  32'(bram_addra), 0);
        check({tag, "_dina"},   32'(bram_dina),  0);
        check({tag, "_addrb"},  32'(bram_addrb), 0);
        check({tag, "_readys"}, 32'({wr0_ready, wr1_ready, rd0_ready, rd1_ready}), 0);
        check({tag, "_rvalid"}, 32'({rd0_rvalid, rd1_rvalid}), 0);
        check({tag, "_rdata0"}, 32'(rd0_rdata), 0);
        check({tag, "_rdata1"}, 32'(rd1_rdata), 0);
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        #1;
        check_reset_outputs("rst");
        cyc();
        rst_n = 1;
        #1;
    endtask

    task automatic write0(input logic [3:0] a, input logic [15:0] d);
        wr0_valid = 1; wr0_addr = a; wr0_data = d;
        cyc();
        wr0_valid = 0;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
        bram_doutb = 16'h0000;
        wr0_addr = 0; wr0_data = 0; wr1_addr = 0; wr1_data = 0;
        rd0_addr = 0; rd1_addr = 0;
        idle();
        rst_n = 0;
        cyc();
        cyc();
        check_reset_outputs("init");
        rst_n = 1;
        #1;

        // 1: write then read one address, response after two cycles.
        wr0_valid = 1; wr0_addr = 4'd3; wr0_data = 16'hBEEF;
        #1 check("t1_wr0_ready", 32'(wr0_ready), 1);
        cyc();
        wr0_valid = 0;
        check("t1_wea", 32'(bram_wea), 1);
        check("t1_addra", 32'(bram_addra), 3);
        check("t1_dina", 32'(bram_dina), 32'h0000BEEF);
        rd0_valid = 1; rd0_addr = 4'd3;
        #1 check("t1_rd0_ready", 32'(rd0_ready), 1);
        cyc();
        rd0_valid = 0;
        check("t1_addrb", 32'(bram_addrb), 3);
        check("t1_rvalid_early", 32'({rd0_rvalid, rd1_rvalid}), 0);
        check("t1_wea_off", 32'(bram_wea), 0);
        cyc();
        check("t1_rvalid", 32'({rd0_rvalid, rd1_rvalid}), 32'b10);
        check("t1_rdata", 32'(rd0_rdata), 32'h0000BEEF);
        cyc();
        check("t1_rvalid_after", 32'({rd0_rvalid, rd1_rvalid}), 0);
        check("t1_rdata_hold", 32'(rd0_rdata), 32'h0000BEEF);

        // 2: both writers held valid for 4 cycles -> 0,1,0,1.
        do_reset();
        wr0_addr = 4'd6; wr0_data = 16'h6060;
        wr1_addr = 4'd7; wr1_data = 16'h7070;
        for (int i = 0; i < 4; i++) begin
            wr0_valid = 1; wr1_valid = 1;
            #1;
            check("t2_wr0_ready", 32'(wr0_ready), 32'((i % 2) == 0));
            check("t2_wr1_ready", 32'(wr1_ready), 32'((i % 2) == 1));
            cyc();
            check("t2_wea", 32'(bram_wea), 1);
            check("t2_addra", 32'(bram_addra), ((i % 2) == 0) ? 32'd6 : 32'd7);
            check("t2_dina", 32'(bram_dina), ((i % 2) == 0) ? 32'h6060 : 32'h7070);
        end
        idle();
        cyc();
        check("t2_wea_off", 32'(bram_wea), 0);

        // 3: two readers held valid, back-to-back alternating responses.
        write0(4'd1, 16'h0011);
        write0(4'd2, 16'h0022);
        rd0_addr = 4'd1; rd1_addr = 4'd2;
        for (int j = 0; j < 6; j++) begin
            rd0_valid = (j < 4); rd1_valid = (j < 4);
            if (j < 4) begin
                #1 check("t3_rd0_ready", 32'(rd0_ready), 32'((j % 2) == 0));
            end
            cyc();
            if (j >= 1 && j <= 4) begin
                if (((j - 1) % 2) == 0) begin
                    check("t3_rvalid", 32'({rd0_rvalid, rd1_rvalid}), 32'b10);
                    check("t3_rd0_rdata", 32'(rd0_rdata), 32'h0011);
                end else begin
                    check("t3_rvalid", 32'({rd0_rvalid, rd1_rvalid}), 32'b01);
                    check("t3_rd1_rdata", 32'(rd1_rdata), 32'h0022);
                end
            end else begin
                check("t3_rvalid_idle", 32'({rd0_rvalid, rd1_rvalid}), 0);
            end
        end
        idle();

        // 4: same-cycle write and read to address 5.
        wr0_valid = 1; wr0_addr = 4'd5; wr0_data = 16'h1234;
        rd0_valid = 1; rd0_addr = 4'd5;
        #1 check("t4_readys", 32'({wr0_ready, rd0_ready}), 32'b11);
        cyc();
        idle();
        check("t4_pins", 32'({bram_wea, bram_addra, bram_addrb}), 32'({1'b1, 4'd5, 4'd5}));
        cyc();
        check("t4_rvalid", 32'({rd0_rvalid, rd1_rvalid}), 32'b10);
`ifdef BRAM_RAW_BYPASS_EN
        check("t4_bypass_data", 32'(rd0_rdata), 32'h1234);
`endif
        cyc();
        check("t4_rvalid_after", 32'({rd0_rvalid, rd1_rvalid}), 0);

        // 5: reset with two reads in flight; pointers favour 0 afterwards.
        rd0_valid = 1; rd0_addr = 4'd1;
        cyc();
        rd0_addr = 4'd2;
        cyc();
        idle();
        rst_n = 0;
        #1;
        check_reset_outputs("t5_rst");
        cyc();
        rst_n = 1;
        #1;
        for (int j = 0; j < 4; j++) begin
            check("t5_no_rvalid", 32'({rd0_rvalid, rd1_rvalid}), 0);
            cyc();
        end
        wr0_valid = 1; wr1_valid = 1; rd0_valid = 1; rd1_valid = 1;
        #1;
        check("t5_rr_ptrs", 32'({wr0_ready, wr1_ready, rd0_ready, rd1_ready}), 32'b1010);
        idle();
        cyc();
        idle();
        cyc();
        cyc();

        // 6: top and bottom addresses.
        write0(4'd15, 16'hFFFF);
        write0(4'd0, 16'h0001);
        rd0_valid = 1; rd0_addr = 4'd15;
        cyc();
        check("t6_addrb_top", 32'(bram_addrb), 15);
        rd0_addr = 4'd0;
        cyc();
        idle();
        check("t6_addrb_bot", 32'(bram_addrb), 0);
        check("t6_top", 32'({rd0_rvalid, rd0_rdata}), 32'({1'b1, 16'hFFFF}));
        cyc();
        check("t6_bot", 32'({rd0_rvalid, rd0_rdata}), 32'({1'b1, 16'h0001}));
        cyc();
        check("t6_idle", 32'({rd0_rvalid, rd1_rvalid}), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
